// File: rtl/bip_pkg.sv
// Shared definitions for the accumulator-CPU instruction sequencer:
// opcodes, FSM state encoding, accumulator mux selects and the control vector.
package bip_pkg;

  localparam int NBITS_O_DEF = 11;
  localparam int NBITS_D_DEF = 16;
  localparam int CELDAS_DEF  = 10;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_RAM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

endpackage

// File: rtl/bip_control_if.sv
// Program-memory and datapath-control bus of the sequencer.
// master = sequencer side, slave = memory/datapath side.
interface bip_control_if #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16
);
  logic [NBITS_O-1:0] addr;
  logic [NBITS_D-1:0] instr;
  logic [NBITS_O-1:0] operand;
  logic [1:0]         sel_a;
  logic               sel_b;
  logic               op;
  logic               wr_acc;
  logic               wr_ram;
  logic               rd_ram;

  modport master (
    output addr, operand, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram,
    input  instr
  );

  modport slave (
    input  addr, operand, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram,
    output instr
  );
endinterface

// File: rtl/bip_control_decoder.sv
// Opcode to datapath control vector; purely combinational, ungated.
// Unlisted opcodes decode as NOP (all zeros).
module bip_decoder
  import bip_pkg::*;
(
  input  logic [4:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_STO: ctrl.wr_ram = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_a  = SELA_RAM;
        ctrl.wr_acc = 1'b1;
      end
      OP_LDI: begin
        ctrl.sel_a  = SELA_IMM;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_b  = 1'b0;
        ctrl.op     = (opcode == OP_SUB);
        ctrl.sel_a  = SELA_ALU;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.sel_b  = 1'b1;
        ctrl.op     = (opcode == OP_SUBI);
        ctrl.sel_a  = SELA_ALU;
        ctrl.wr_acc = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// Instruction sequencer: PC, fetch/exec FSM, EXEC-gated control strobes.
// Optional busy-cycle counter under BIP_CONTROL_CYCLE_COUNT_EN.
//
// state | meaning
// IDLE  | after reset, waiting for i_Start
// FETCH | o_Addr = PC, memory registers the word at the next edge
// EXEC  | word valid, strobes asserted for this cycle only
// HALT  | stopped on HLT or run-off; i_Start restarts from PC 0
module bip_control
  import bip_pkg::*;
#(
  parameter int NBITS_O = NBITS_O_DEF,
  parameter int NBITS_D = NBITS_D_DEF,
  parameter int CELDAS  = CELDAS_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_Start,
  bip_control_if.master bus,
  output logic          o_Busy,
  output logic          o_Halt,
`ifdef BIP_CONTROL_CYCLE_COUNT_EN
  output logic [31:0]   o_CycleCount,
`endif
  output logic          o_Fault
);

  localparam logic [NBITS_O-1:0] LAST_PC = NBITS_O'(CELDAS - 1);

  state_t             state, state_nxt;
  logic [NBITS_O-1:0] pc;
  logic [4:0]         opcode;
  ctrl_t              dec_ctrl;
  logic               start_ok;
  logic               pc_inc;
  logic               fault_set;

  assign opcode = bus.instr[NBITS_D-1 -: 5];

  bip_decoder u_decoder (
    .opcode (opcode),
    .ctrl   (dec_ctrl)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    pc_inc    = 1'b0;
    fault_set = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALT: begin
        if (i_Start) begin
          start_ok  = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (opcode == OP_HLT) begin
          state_nxt = ST_HALT;
        end else if (pc == LAST_PC) begin
          // Halting here keeps the PC from ever wrapping past the program.
          state_nxt = ST_HALT;
          fault_set = 1'b1;
        end else begin
          pc_inc    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc      <= '0;
      o_Fault <= 1'b0;
    end else if (start_ok) begin
      pc      <= '0;
      o_Fault <= 1'b0;
    end else begin
      if (pc_inc)    pc      <= pc + 1'b1;
      if (fault_set) o_Fault <= 1'b1;
    end
  end

  assign bus.operand = bus.instr[NBITS_O-1:0];

  always_comb begin
    bus.addr   = pc;
    bus.sel_a  = SELA_RAM;
    bus.sel_b  = 1'b0;
    bus.op     = 1'b0;
    bus.wr_acc = 1'b0;
    bus.wr_ram = 1'b0;
    bus.rd_ram = 1'b0;
    o_Busy     = (state == ST_FETCH) || (state == ST_EXEC);
    o_Halt     = (state == ST_HALT);
    if (state == ST_EXEC) begin
      bus.sel_a  = dec_ctrl.sel_a;
      bus.sel_b  = dec_ctrl.sel_b;
      bus.op     = dec_ctrl.op;
      bus.wr_acc = dec_ctrl.wr_acc;
      bus.wr_ram = dec_ctrl.wr_ram;
      bus.rd_ram = dec_ctrl.rd_ram;
    end
  end

`ifdef BIP_CONTROL_CYCLE_COUNT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                           o_CycleCount <= '0;
    else if (start_ok)                      o_CycleCount <= '0;
    else if (o_Busy && (o_CycleCount != '1)) o_CycleCount <= o_CycleCount + 1'b1;
  end
`endif

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control with a 1-cycle synchronous program memory.
// Define BIP_CONTROL_CYCLE_COUNT_EN to also exercise the cycle counter.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, halt, fault;
  logic [6:0]  ctl;
  logic [15:0] mem [16];
  int          n_cmp = 0;
  int          n_err = 0;
`ifdef BIP_CONTROL_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  // {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram}
  localparam logic [6:0] C_NONE = 7'b00_0_0_0_0_0;
  localparam logic [6:0] C_STO  = 7'b00_0_0_0_1_0;
  localparam logic [6:0] C_LD   = 7'b00_0_0_1_0_1;
  localparam logic [6:0] C_LDI  = 7'b01_0_0_1_0_0;
  localparam logic [6:0] C_ADD  = 7'b10_0_0_1_0_1;
  localparam logic [6:0] C_ADDI = 7'b10_1_0_1_0_0;
  localparam logic [6:0] C_SUB  = 7'b10_0_1_1_0_1;
  localparam logic [6:0] C_SUBI = 7'b10_1_1_1_0_0;

  bip_control_if #(.NBITS_O(11), .NBITS_D(16)) bus ();

  bip_control dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_Start      (start),
    .bus          (bus),
    .o_Busy       (busy),
    .o_Halt       (halt),
`ifdef BIP_CONTROL_CYCLE_COUNT_EN
    .o_CycleCount (cycle_count),
`endif
    .o_Fault      (fault)
  );

  assign ctl = {bus.sel_a, bus.sel_b, bus.op, bus.wr_acc, bus.wr_ram, bus.rd_ram};

  always #5 clk = ~clk;

  initial bus.instr = '0;
  always @(posedge clk) bus.instr <= mem[bus.addr[3:0]];

  task automatic step();
    @(negedge clk);
  endtask

  // Returns at the negedge of cycle 1 (FETCH of PC 0) relative to the start cycle.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_mem(input logic [15:0] w);
    for (int i = 0; i < 16; i++) mem[i] = w;
  endtask

  task automatic test_reset();
    fill_mem(16'h0805);
    pulse_start();
    step();
    n_cmp++;
    if (bus.wr_ram !== 1'b1) begin
      n_err++; $display("FAIL reset_prewrite: wr_ram=%b want 1", bus.wr_ram);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.wr_ram, busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_abort: wr_ram,busy=%b want 00", {bus.wr_ram, busy});
    end
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      n_cmp++;
      if ({ctl, busy, halt, fault} !== 10'b0 || bus.addr !== 11'd0) begin
        n_err++;
        $display("FAIL reset_idle c%0d: ctl=%b bhf=%b addr=%0d want 0", c, ctl,
                 {busy, halt, fault}, bus.addr);
      end
    end
  endtask

  task automatic test_basic_program();
    logic [3:0] exp_v;
    fill_mem(16'h0000);
    mem[0] = 16'h1001;  // LD   0x001
    mem[1] = 16'h2802;  // ADDI 0x002
    mem[2] = 16'h0807;  // STO  0x007
    mem[3] = 16'h0000;  // HLT
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      exp_v = {(c == 2 || c == 4), (c == 6), (c >= 1 && c <= 8), (c >= 9)};
      n_cmp++;
      if ({bus.wr_acc, bus.wr_ram, busy, halt} !== exp_v) begin
        n_err++;
        $display("FAIL basic c%0d: wracc,wrram,busy,halt=%b want %b", c,
                 {bus.wr_acc, bus.wr_ram, busy, halt}, exp_v);
      end
      if (c == 2) begin
        n_cmp++;
        if (ctl !== C_LD || bus.operand !== 11'h001) begin
          n_err++; $display("FAIL basic_ld: ctl=%b op=%h want %b 001", ctl, bus.operand, C_LD);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (bus.operand !== 11'h007) begin
          n_err++; $display("FAIL basic_sto_operand: %h want 007", bus.operand);
        end
      end
      if (c == 10) begin
        n_cmp++;
        if (bus.addr !== 11'd3 || fault !== 1'b0) begin
          n_err++; $display("FAIL basic_halt_pc: addr=%0d fault=%b want 3 0", bus.addr, fault);
        end
      end
      step();
    end
  endtask

  task automatic test_decode_sweep();
    logic [6:0] exp_ctl [9];
    exp_ctl[0] = C_STO;  exp_ctl[1] = C_LD;   exp_ctl[2] = C_LDI;
    exp_ctl[3] = C_ADD;  exp_ctl[4] = C_ADDI; exp_ctl[5] = C_SUB;
    exp_ctl[6] = C_SUBI; exp_ctl[7] = C_NONE; exp_ctl[8] = C_NONE;
    fill_mem(16'h0000);
    mem[0] = 16'h0810; mem[1] = 16'h1011; mem[2] = 16'h1812;
    mem[3] = 16'h2013; mem[4] = 16'h2814; mem[5] = 16'h3015;
    mem[6] = 16'h3816; mem[7] = 16'hF817; mem[8] = 16'h0018;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      step();
      n_cmp++;
      if (ctl !== exp_ctl[i] || bus.addr !== 11'(i) || bus.operand !== 11'(i + 16)) begin
        n_err++;
        $display("FAIL decode_%0d: ctl=%b addr=%0d opnd=%h want %b %0d %h", i, ctl,
                 bus.addr, bus.operand, exp_ctl[i], i, i + 16);
      end
      step();
      if (i < 8) begin
        n_cmp++;
        if (ctl !== C_NONE || bus.addr !== 11'(i + 1) || busy !== 1'b1) begin
          n_err++;
          $display("FAIL decode_fetch_%0d: ctl=%b addr=%0d busy=%b want 0 %0d 1", i + 1,
                   ctl, bus.addr, busy, i + 1);
        end
      end
    end
    n_cmp++;
    if (halt !== 1'b1 || busy !== 1'b0 || bus.addr !== 11'd8 || ctl !== C_NONE) begin
      n_err++;
      $display("FAIL decode_halt: halt=%b busy=%b addr=%0d ctl=%b want 1 0 8 0", halt, busy,
               bus.addr, ctl);
    end
  endtask

  task automatic test_run_off_fault();
    int n;
    fill_mem(16'h4000);
    pulse_start();
    n = 1;
    while (!halt && n < 60) begin step(); n++; end
    n_cmp++;
    if (halt !== 1'b1 || n != 21 || fault !== 1'b1 || bus.addr !== 11'd9) begin
      n_err++;
      $display("FAIL runoff: halt=%b cycle=%0d fault=%b addr=%0d want 1 21 1 9", halt, n,
               fault, bus.addr);
    end
    pulse_start();
    n_cmp++;
    if (fault !== 1'b0 || bus.addr !== 11'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL runoff_restart: fault=%b addr=%0d busy=%b want 0 0 1", fault, bus.addr, busy);
    end
    n = 1;
    while (!halt && n < 60) begin step(); n++; end
    n_cmp++;
    if (halt !== 1'b1 || fault !== 1'b1) begin
      n_err++; $display("FAIL runoff_second: halt=%b fault=%b want 1 1", halt, fault);
    end
  endtask

  task automatic test_start_while_busy();
    fill_mem(16'hF800);
    mem[3] = 16'h0000;
    pulse_start();
    start = 1'b1;
    step();
    n_cmp++;
    if (bus.addr !== 11'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL busy_exec0: addr=%0d busy=%b want 0 1", bus.addr, busy);
    end
    step();
    start = 1'b0;
    n_cmp++;
    if (bus.addr !== 11'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL busy_fetch1: addr=%0d busy=%b want 1 1", bus.addr, busy);
    end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (bus.addr !== 11'd2) begin
      n_err++; $display("FAIL busy_fetch2: addr=%0d want 2", bus.addr);
    end
    repeat (4) step();
    n_cmp++;
    if (halt !== 1'b1 || bus.addr !== 11'd3 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL busy_halt: halt=%b addr=%0d fault=%b want 1 3 0", halt, bus.addr, fault);
    end
  endtask

`ifdef BIP_CONTROL_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    int n;
    fill_mem(16'h0000);
    mem[0] = 16'h1805; mem[1] = 16'h2801; mem[2] = 16'h0803; mem[3] = 16'h0000;
    pulse_start();
    n_cmp++;
    if (cycle_count !== 32'd0) begin
      n_err++; $display("FAIL count_clear: %0d want 0", cycle_count);
    end
    n = 1;
    while (!halt && n < 40) begin step(); n++; end
    n_cmp++;
    if (halt !== 1'b1 || cycle_count !== 32'd8) begin
      n_err++; $display("FAIL count_halt: halt=%b count=%0d want 1 8", halt, cycle_count);
    end
    repeat (5) step();
    n_cmp++;
    if (cycle_count !== 32'd8) begin
      n_err++; $display("FAIL count_hold: %0d want 8", cycle_count);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill_mem(16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    test_reset();
    test_basic_program();
    test_decode_sweep();
    test_run_off_fault();
    test_start_while_busy();
`ifdef BIP_CONTROL_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
